// File: rtl/brc_pkg.sv
// ============================================================================
// brc_pkg : shared funct3 encodings and BHT counter type for branch resolve
// Revision: 1.0
// ============================================================================
`default_nettype none

package brc_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef logic [1:0] bht_cnt_t;

    localparam bht_cnt_t BHT_RESET = 2'b01;

    function automatic bht_cnt_t bht_next(input bht_cnt_t cnt, input logic taken);
        bht_cnt_t nxt;
        nxt = cnt;
        if (taken && cnt != 2'b11) begin
            nxt = cnt + 2'b01;
        end else if (!taken && cnt != 2'b00) begin
            nxt = cnt - 2'b01;
        end
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/brc_bht.sv
// ============================================================================
// brc_bht : 2-bit saturating branch history table, comb read, sync update
// Revision: 1.0
// ============================================================================
`default_nettype none

module brc_bht
    import brc_pkg::*;
#(
    parameter int ENTRIES = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [$clog2(ENTRIES)-1:0] rd_idx_i,
    output logic                       rd_taken_o,
    input  logic                       upd_en_i,
    input  logic [$clog2(ENTRIES)-1:0] upd_idx_i,
    input  logic                       upd_taken_i
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0][1:0] cnt_w;

    generate
        for (genvar i = 0; i < ENTRIES; i++) begin : g_cnt
            bht_cnt_t cnt_q;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    cnt_q <= BHT_RESET;
                end else if (upd_en_i && upd_idx_i == IDX_W'(i)) begin
                    cnt_q <= bht_next(cnt_q, upd_taken_i);
                end
            end

            assign cnt_w[i] = cnt_q;
        end
    endgenerate

    // Read sees the stored value, so a same-index update shows up next cycle.
    assign rd_taken_o = cnt_w[rd_idx_i][1];

endmodule

`default_nettype wire

// File: rtl/brc_resolve_unit.sv
// ============================================================================
// brc_resolve_unit : EX branch resolution, mispredict redirect and BHT owner
// Revision: 1.0
// ============================================================================
`default_nettype none

module brc_resolve_unit
    import brc_pkg::*;
#(
    parameter int BHT_ENTRIES = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ex_valid_i,
    input  logic             ex_is_branch_i,
    input  logic             ex_is_jump_i,
    input  logic [2:0]       ex_funct3_i,
    input  logic [31:0]      ex_pc_i,
    input  logic [31:0]      ex_target_i,
    input  logic             ex_pred_taken_i,
    input  logic             A_eq_B_i,
    input  logic             A_lt_B_i,
    input  logic             A_ltu_B_i,
    input  logic [31:0]      if_pc_i,
    output logic             if_pred_taken_o,
    output logic             redirect_valid_o,
    output logic [31:0]      redirect_pc_o,
    input  logic             redirect_ready_i,
    output logic             flush_o,
    output logic             ex_stall_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    localparam int IDX = $clog2(BHT_ENTRIES);

    logic             redirect_valid_q, redirect_valid_d;
    logic [31:0]      redirect_pc_q,    redirect_pc_d;
    logic             illegal_q,        illegal_d;
    logic [CNT_W-1:0] mispred_cnt_q,    mispred_cnt_d;

    logic             w_resolve;
    logic             w_taken;
    logic             w_illegal;
    logic             w_mispredict;
    logic             w_bht_upd;
    logic [31:0]      w_actual_pc;
    logic             w_unused;

    assign ex_stall_o = redirect_valid_q & ~redirect_ready_i;
    assign flush_o    = redirect_valid_q &  redirect_ready_i;
    assign w_resolve  = ex_valid_i & (ex_is_branch_i | ex_is_jump_i) & ~ex_stall_o;

    always_comb begin
        w_taken   = 1'b0;
        w_illegal = 1'b0;
        case (ex_funct3_i)
            F3_BEQ:  w_taken = A_eq_B_i;
            F3_BNE:  w_taken = ~A_eq_B_i;
            F3_BLT:  w_taken = A_lt_B_i;
            F3_BGE:  w_taken = ~A_lt_B_i;
            F3_BLTU: w_taken = A_ltu_B_i;
            F3_BGEU: w_taken = ~A_ltu_B_i;
            default: w_illegal = 1'b1;
        endcase
        // Jumps win over the branch decode when both type bits are set.
        if (ex_is_jump_i) begin
            w_taken   = 1'b1;
            w_illegal = 1'b0;
        end else if (!ex_is_branch_i) begin
            w_taken   = 1'b0;
            w_illegal = 1'b0;
        end
    end

    assign w_actual_pc  = w_taken ? ex_target_i : ex_pc_i + 32'd4;
    assign w_mispredict = w_resolve & (w_taken != ex_pred_taken_i);
    assign w_bht_upd    = w_resolve & ex_is_branch_i & ~ex_is_jump_i & ~w_illegal;

    always_comb begin
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        mispred_cnt_d    = mispred_cnt_q;
        illegal_d        = w_resolve & w_illegal;
        if (redirect_valid_q && redirect_ready_i) begin
            redirect_valid_d = 1'b0;
        end
        if (w_mispredict) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = w_actual_pc;
            if (mispred_cnt_q != {CNT_W{1'b1}}) begin
                mispred_cnt_d = mispred_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
            illegal_q        <= 1'b0;
            mispred_cnt_q    <= '0;
        end else begin
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            illegal_q        <= illegal_d;
            mispred_cnt_q    <= mispred_cnt_d;
        end
    end

    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign illegal_o        = illegal_q;
    assign mispred_cnt_o    = mispred_cnt_q;

    brc_bht #(
        .ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rd_idx_i    (if_pc_i[IDX+1:2]),
        .rd_taken_o  (if_pred_taken_o),
        .upd_en_i    (w_bht_upd),
        .upd_idx_i   (ex_pc_i[IDX+1:2]),
        .upd_taken_i (w_taken)
    );

    assign w_unused = ^{if_pc_i[31:IDX+2], if_pc_i[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_brc_resolve_unit.sv
// ============================================================================
// tb_brc_resolve_unit : directed self-checking bench for brc_resolve_unit
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_brc_resolve_unit;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        ex_valid_i, ex_is_branch_i, ex_is_jump_i, ex_pred_taken_i;
    logic [2:0]  ex_funct3_i;
    logic [31:0] ex_pc_i, ex_target_i, if_pc_i, redirect_pc_o;
    logic        A_eq_B_i, A_lt_B_i, A_ltu_B_i;
    logic        if_pred_taken_o, redirect_valid_o, redirect_ready_i;
    logic        flush_o, ex_stall_o, illegal_o;
    logic [1:0]  mispred_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Two-bit statistics counter so saturation is reachable in a few mispredicts.
    brc_resolve_unit #(
        .BHT_ENTRIES (16),
        .CNT_W       (2)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .ex_valid_i       (ex_valid_i),
        .ex_is_branch_i   (ex_is_branch_i),
        .ex_is_jump_i     (ex_is_jump_i),
        .ex_funct3_i      (ex_funct3_i),
        .ex_pc_i          (ex_pc_i),
        .ex_target_i      (ex_target_i),
        .ex_pred_taken_i  (ex_pred_taken_i),
        .A_eq_B_i         (A_eq_B_i),
        .A_lt_B_i         (A_lt_B_i),
        .A_ltu_B_i        (A_ltu_B_i),
        .if_pc_i          (if_pc_i),
        .if_pred_taken_o  (if_pred_taken_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .redirect_ready_i (redirect_ready_i),
        .flush_o          (flush_o),
        .ex_stall_o       (ex_stall_o),
        .illegal_o        (illegal_o),
        .mispred_cnt_o    (mispred_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid_i      = 1'b0;
        ex_is_branch_i  = 1'b0;
        ex_is_jump_i    = 1'b0;
        ex_funct3_i     = 3'b000;
        ex_pc_i         = 32'd0;
        ex_target_i     = 32'd0;
        ex_pred_taken_i = 1'b0;
        A_eq_B_i        = 1'b0;
        A_lt_B_i        = 1'b0;
        A_ltu_B_i       = 1'b0;
    endtask

    task automatic br(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                      input logic pred, input logic eq, input logic lt, input logic ltu,
                      input logic jmp);
        ex_valid_i      = 1'b1;
        ex_is_branch_i  = 1'b1;
        ex_is_jump_i    = jmp;
        ex_funct3_i     = f3;
        ex_pc_i         = pc;
        ex_target_i     = tgt;
        ex_pred_taken_i = pred;
        A_eq_B_i        = eq;
        A_lt_B_i        = lt;
        A_ltu_B_i       = ltu;
    endtask

    initial begin
        idle();
        rst_i            = 1'b1;
        redirect_ready_i = 1'b0;
        if_pc_i          = 32'h40;
        #1;
        chk("rst_valid",   32'(redirect_valid_o), 32'd0);
        chk("rst_pc",      redirect_pc_o,         32'd0);
        chk("rst_illegal", 32'(illegal_o),        32'd0);
        chk("rst_cnt",     32'(mispred_cnt_o),    32'd0);
        chk("rst_flush",   32'(flush_o),          32'd0);
        chk("rst_stall",   32'(ex_stall_o),       32'd0);
        chk("rst_pred",    32'(if_pred_taken_o),  32'd0);
        tick();
        rst_i = 1'b0;
        tick();

        // BEQ taken, predicted not taken: redirect to target
        br(3'b000, 32'h100, 32'h140, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        if_pc_i = 32'h100;
        #1;
        chk("beq_pred_pre_update", 32'(if_pred_taken_o), 32'd0);
        tick();
        idle();
        #1;
        chk("beq_valid",  32'(redirect_valid_o), 32'd1);
        chk("beq_pc",     redirect_pc_o,         32'h140);
        chk("beq_cnt",    32'(mispred_cnt_o),    32'd1);
        chk("beq_pred",   32'(if_pred_taken_o),  32'd1);
        redirect_ready_i = 1'b1;
        #1;
        chk("beq_flush",  32'(flush_o),          32'd1);
        chk("beq_nostall", 32'(ex_stall_o),      32'd0);
        tick();
        redirect_ready_i = 1'b0;
        #1;
        chk("beq_cleared", 32'(redirect_valid_o), 32'd0);
        chk("beq_flush_off", 32'(flush_o),        32'd0);

        // BLT not taken, predicted taken: redirect to pc+4
        br(3'b100, 32'h200, 32'h300, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        #1;
        chk("blt_valid", 32'(redirect_valid_o), 32'd1);
        chk("blt_pc",    redirect_pc_o,         32'h204);
        chk("blt_cnt",   32'(mispred_cnt_o),    32'd2);
        redirect_ready_i = 1'b1;
        tick();
        redirect_ready_i = 1'b0;

        // BGEU with ltu=1: not taken, correctly predicted; counter saturates low
        if_pc_i = 32'h84;
        br(3'b111, 32'h84, 32'h500, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("bgeu_no_redirect", 32'(redirect_valid_o), 32'd0);
        tick();
        idle();
        #1;
        chk("bgeu_pred_sat0", 32'(if_pred_taken_o), 32'd0);
        br(3'b000, 32'h84, 32'h500, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        #1;
        chk("bgeu_pred_after_inc", 32'(if_pred_taken_o), 32'd0);
        chk("bgeu_cnt", 32'(mispred_cnt_o), 32'd2);

        // BNE taken mispredict, then IF holds off for three cycles
        br(3'b001, 32'h300, 32'h380, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        br(3'b000, 32'h500, 32'h600, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_stall", 32'(ex_stall_o),       32'd1);
            chk("stall_pc",    redirect_pc_o,         32'h380);
            chk("stall_flush", 32'(flush_o),          32'd0);
            tick();
        end
        idle();
        chk("stall_cnt", 32'(mispred_cnt_o), 32'd3);
        redirect_ready_i = 1'b1;
        #1;
        chk("stall_flush_hs", 32'(flush_o), 32'd1);
        tick();
        redirect_ready_i = 1'b0;
        #1;
        chk("stall_flush_off", 32'(flush_o),          32'd0);
        chk("stall_valid_off", 32'(redirect_valid_o), 32'd0);
        chk("stall_pc_kept",   redirect_pc_o,         32'h380);

        // Reserved funct3: illegal pulse, not taken, BHT untouched
        if_pc_i = 32'h8;
        br(3'b010, 32'h8, 32'h100, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        idle();
        #1;
        chk("ill_pulse",  32'(illegal_o),        32'd1);
        chk("ill_no_red", 32'(redirect_valid_o), 32'd0);
        tick();
        chk("ill_pulse_end", 32'(illegal_o), 32'd0);
        br(3'b000, 32'h8, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        #1;
        chk("ill_bht_unchanged", 32'(if_pred_taken_o), 32'd1);

        // BNE not taken at top of address space: pc+4 wraps; stats saturate
        br(3'b001, 32'hFFFF_FFFC, 32'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        #1;
        chk("wrap_valid",  32'(redirect_valid_o), 32'd1);
        chk("wrap_pc",     redirect_pc_o,         32'h0);
        chk("wrap_cnt_sat", 32'(mispred_cnt_o),   32'd3);
        redirect_ready_i = 1'b1;
        tick();
        redirect_ready_i = 1'b0;

        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tick();

        // Three taken branches at 0x40 from reset: 01 -> 10 -> 11 -> 11
        if_pc_i = 32'h40;
        br(3'b000, 32'h40, 32'h80, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("t40_pred_pre", 32'(if_pred_taken_o), 32'd0);
        tick();
        chk("t40_pred_1", 32'(if_pred_taken_o), 32'd1);
        tick();
        tick();
        br(3'b000, 32'h40, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        #1;
        chk("t40_sat_hi",   32'(if_pred_taken_o),  32'd1);
        chk("t40_no_red",   32'(redirect_valid_o), 32'd0);

        // Jump with branch bit also set: taken to target, BHT untouched
        br(3'b000, 32'h40, 32'h1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        br(3'b000, 32'h40, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        #1;
        chk("jmp_valid", 32'(redirect_valid_o), 32'd1);
        chk("jmp_pc",    redirect_pc_o,         32'h1000);
        chk("jmp_cnt",   32'(mispred_cnt_o),    32'd1);
        chk("jmp_bht_held", 32'(if_pred_taken_o), 32'd1);

        // Reset in the middle of the pending redirect
        rst_i            = 1'b1;
        redirect_ready_i = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(redirect_valid_o), 32'd0);
        chk("rst_mid_flush", 32'(flush_o),          32'd0);
        chk("rst_mid_cnt",   32'(mispred_cnt_o),    32'd0);
        chk("rst_mid_bht",   32'(if_pred_taken_o),  32'd0);
        tick();
        rst_i            = 1'b0;
        redirect_ready_i = 1'b0;
        br(3'b000, 32'h40, 32'h80, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        #1;
        chk("rst_mid_bht_01", 32'(if_pred_taken_o), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
